// File: rtl/clock_measure_pkg.sv
// rtl/clock_measure_pkg.sv - shared state encoding and default sizing for the clock measurement sequencer
package clock_measure_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT_VALID,
        HOLDOFF,
        ERROR
    } clock_measure_state_t;

    localparam int CM_COUNTER_WIDTH  = 64;
    localparam int CM_INTERVAL_WIDTH = 32;
    localparam int CM_TIMEOUT_CYCLES = 1048576;

endpackage

// File: rtl/clock_measure_interval_timer.sv
// rtl/clock_measure_interval_timer.sv - loadable down-counter with clear and expiry flag
module clock_measure_interval_timer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_en,
    input  logic             i_clear,
    output logic             o_expired
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = i_load_value;
        end else if (i_en && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // High in the cycle whose edge takes the count from 1 to 0.
    assign o_expired = i_en && (count_q == ONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clock_measure_ctrl.sv
// rtl/clock_measure_ctrl.sv - one-shot/periodic latch sequencer for clock_counter; CLOCK_MEASURE_TIMEOUT_EN adds a handshake watchdog
module clock_measure_ctrl
    import clock_measure_pkg::*;
#(
    parameter int CLOCK_COUNTER_WIDTH = CM_COUNTER_WIDTH,
    parameter int INTERVAL_WIDTH      = CM_INTERVAL_WIDTH,
    parameter int TIMEOUT_CYCLES      = CM_TIMEOUT_CYCLES
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_periodic_en,
    input  logic [INTERVAL_WIDTH-1:0]      i_interval,
    input  logic                           i_clear_err,
    output logic                           o_latch_counters,
    input  logic                           i_counter_valid,
    input  logic [CLOCK_COUNTER_WIDTH-1:0] i_local_count,
    input  logic [CLOCK_COUNTER_WIDTH-1:0] i_extern_count,
    output logic [CLOCK_COUNTER_WIDTH-1:0] o_local_count,
    output logic [CLOCK_COUNTER_WIDTH-1:0] o_extern_count,
    output logic                           o_result_valid,
    output logic [15:0]                    o_sample_count,
    output logic                           o_busy,
    output logic                           o_timeout
);

    clock_measure_state_t state_q, state_d;

    logic                           latch_q, latch_d;
    logic                           busy_q, busy_d;
    logic                           result_valid_q, result_valid_d;
    logic                           measured_q, measured_d;
    logic [15:0]                    sample_count_q, sample_count_d;
    logic [CLOCK_COUNTER_WIDTH-1:0] local_q, local_d;
    logic [CLOCK_COUNTER_WIDTH-1:0] extern_q, extern_d;

    logic                      capture;
    logic                      holdoff_expired;
    logic                      wd_expired;
    logic [INTERVAL_WIDTH-1:0] holdoff_value;

    assign capture       = (state_q == WAIT_VALID) && i_counter_valid;
    assign holdoff_value = (i_interval == '0) ? INTERVAL_WIDTH'(1) : i_interval;

    clock_measure_interval_timer #(
        .WIDTH (INTERVAL_WIDTH)
    ) u_holdoff_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       ((state_d == HOLDOFF) && (state_q != HOLDOFF)),
        .i_load_value (holdoff_value),
        .i_en         (state_q == HOLDOFF),
        .i_clear      (state_d != HOLDOFF),
        .o_expired    (holdoff_expired)
    );

`ifdef CLOCK_MEASURE_TIMEOUT_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic measuring_q;
    logic measuring_d;
    logic timeout_q;

    assign measuring_q = (state_q == LATCH) || (state_q == WAIT_VALID);
    assign measuring_d = (state_d == LATCH) || (state_d == WAIT_VALID);

    // Armed once per measurement; the LATCH->WAIT_VALID step keeps counting.
    clock_measure_interval_timer #(
        .WIDTH (WD_WIDTH)
    ) u_watchdog_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (measuring_d && !measuring_q),
        .i_load_value (WD_WIDTH'(TIMEOUT_CYCLES)),
        .i_en         (measuring_q),
        .i_clear      (!measuring_d),
        .o_expired    (wd_expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state_d == ERROR);
        end
    end

    assign o_timeout = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign wd_expired = 1'b0;
    assign o_timeout  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start || (i_periodic_en && !measured_q)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (!i_counter_valid) begin
                    state_d = WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                if (i_counter_valid) begin
                    state_d = i_periodic_en ? HOLDOFF : IDLE;
                end
            end
            HOLDOFF: begin
                // A start request and a simultaneous expiry collapse into one LATCH.
                if (i_start) begin
                    state_d = LATCH;
                end else if (!i_periodic_en) begin
                    state_d = IDLE;
                end else if (holdoff_expired) begin
                    state_d = LATCH;
                end
            end
            ERROR: begin
                if (i_clear_err) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wd_expired && !capture) begin
            state_d = ERROR;
        end
    end

    always_comb begin
        latch_d        = (state_d == LATCH);
        busy_d         = (state_d != IDLE);
        result_valid_d = capture;
        measured_d     = measured_q || capture;
        sample_count_d = capture ? (sample_count_q + 16'd1) : sample_count_q;
        local_d        = capture ? i_local_count : local_q;
        extern_d       = capture ? i_extern_count : extern_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= IDLE;
            latch_q        <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            measured_q     <= 1'b0;
            sample_count_q <= '0;
            local_q        <= '0;
            extern_q       <= '0;
        end else begin
            state_q        <= state_d;
            latch_q        <= latch_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            measured_q     <= measured_d;
            sample_count_q <= sample_count_d;
            local_q        <= local_d;
            extern_q       <= extern_d;
        end
    end

    assign o_latch_counters = latch_q;
    assign o_busy           = busy_q;
    assign o_result_valid   = result_valid_q;
    assign o_sample_count   = sample_count_q;
    assign o_local_count    = local_q;
    assign o_extern_count   = extern_q;

endmodule
